// File: rtl/uwb_spi_master.sv
// uwb_spi_master: length-prefixed byte stream to SPI mode-0 master, MSB first, one CS_n window per packet.
// Define SPI_RX_CAPTURE_EN to capture MISO bytes onto rx_data/rx_valid; otherwise both are tied low.
module uwb_spi_master #(
   parameter int CLK_DIV = 1,
   parameter int CS_IDLE = 2,
   parameter int MAX_LEN = 127
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       spi_cs_n,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       len_err
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_GAP = 2'd3;
   localparam logic [15:0] LP_HALF = 16'(CLK_DIV - 1);
   localparam logic [15:0] LP_TAIL = 16'(CLK_DIV + CS_IDLE - 1);
   localparam logic [7:0] LP_MAX = 8'(MAX_LEN);
   logic [1:0] r_state;
   logic [15:0] r_cnt;
   logic [2:0] r_bit;
   logic [7:0] r_rem, r_sh, r_rx, r_rx_data;
   logic r_init, r_cs_n, r_sck, r_mosi, r_busy, r_err, r_rx_valid;
   logic w_accept, w_half;
   // r_init holds in_ready low for the first cycle after reset
   assign in_ready = ~r_init & (r_state == S_IDLE | r_state == S_LOAD);
   assign w_accept = in_valid & in_ready;
   assign w_half = r_cnt == LP_HALF;
   assign spi_cs_n = r_cs_n;
   assign spi_sck = r_sck;
   assign spi_mosi = r_mosi;
   assign busy = r_busy;
   assign len_err = r_err;
`ifdef SPI_RX_CAPTURE_EN
   assign rx_data = r_rx_data;
   assign rx_valid = r_rx_valid;
`else
   logic w_unused_rx;
   assign w_unused_rx = ^{r_rx_data, r_rx_valid};
   assign rx_data = 8'd0;
   assign rx_valid = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt <= 16'd0;
         r_bit <= 3'd0;
         r_rem <= 8'd0;
         r_sh <= 8'd0;
         r_rx <= 8'd0;
         r_rx_data <= 8'd0;
         r_rx_valid <= 1'b0;
         r_init <= 1'b1;
         r_cs_n <= 1'b1;
         r_sck <= 1'b0;
         r_mosi <= 1'b0;
         r_busy <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_init <= 1'b0;
         r_err <= 1'b0;
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: if (w_accept && in_data != 8'd0) begin
               if (in_data > LP_MAX) r_err <= 1'b1;
               else begin
                  r_rem <= in_data;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: if (w_accept) begin
               r_sh <= in_data;
               r_mosi <= in_data[7];
               r_cs_n <= 1'b0;
               r_busy <= 1'b1;
               r_cnt <= 16'd0;
               r_bit <= 3'd0;
               r_state <= S_SHIFT;
            end
            S_SHIFT: if (!w_half) r_cnt <= r_cnt + 16'd1;
            else begin
               r_cnt <= 16'd0;
               r_sck <= ~r_sck;
               if (!r_sck) r_rx <= {r_rx[6:0], spi_miso};
               else if (r_bit != 3'd7) begin
                  r_bit <= r_bit + 3'd1;
                  r_sh <= {r_sh[6:0], 1'b0};
                  r_mosi <= r_sh[6];
               end else begin
                  r_rx_data <= r_rx;
                  r_rx_valid <= 1'b1;
                  r_rem <= r_rem - 8'd1;
                  r_state <= (r_rem == 8'd1) ? S_GAP : S_LOAD;
               end
            end
            S_GAP: begin
               // CS_n stays low for one more half period, then the idle gap runs
               r_cnt <= r_cnt + 16'd1;
               if (r_cnt == LP_HALF) r_cs_n <= 1'b1;
               if (r_cnt == LP_TAIL) begin
                  r_busy <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule
